mem_arbiter: RTL
================

Name: mem_arbiter

Overview:
- Sequences the single shared main-memory port between the instruction-side and data-side miss paths of the CPU.
- Read requests fetch a whole block as BLOCK_WORDS pipelined word reads and stream the returned words back to the granted requester.
- Data-side stores are single-word writes.
- Sits between the instruction/data caches and the multi-cycle data_memory-style main memory.

Parameters:
BLOCK_WORDS, 8, words per cache block; power of two ≥2; block = 2*BLOCK_WORDS bytes
ADDR_W, 16, byte address width

Ports:
clk  input  1  clock
rst  input  1  synchronous reset, active-high
i_req  input  1  instruction block-read request; level, held until i_done
i_addr  input  ADDR_W  instruction miss byte address
d_req  input  1  data request; level, held until d_done
d_we  input  1  1 = single-word write, 0 = block read
d_addr  input  ADDR_W  data byte address
d_wdata  input  16  write data
mem_addr  output  ADDR_W  memory byte address
mem_enable  output  1  memory access strobe
mem_wr  output  1  memory write strobe
mem_wdata  output  16  memory write data
mem_rdata  input  16  memory read data
mem_data_valid  input  1  mem_rdata valid; returns in issue order, fixed latency
fill_data  output  16  returned word (mem_rdata passthrough)
fill_word  output  log2(BLOCK_WORDS)  index of returned word within block
i_fill_valid  output  1  fill_data valid for instruction side
d_fill_valid  output  1  fill_data valid for data side
i_done  output  1  one-cycle pulse, instruction transaction complete
d_done  output  1  one-cycle pulse, data transaction complete

Behaviour:
- Reset (rst high at posedge):
  - State IDLE; issue and receive counters cleared; latched address/owner cleared.
  - All strobe outputs (mem_enable, mem_wr, *_fill_valid, *_done) are 0; mem_addr and mem_wdata are 0.
  - Reset mid-transaction abandons it; no done is issued.
  - Main memory shares the same rst, so in-flight read data is flushed.
- States: IDLE, READ, WRITE, RELEASE.
- IDLE: arbitrate with fixed priority, data side over instruction side.
  - d_req and d_we: latch d_addr/d_wdata, owner=D, go to WRITE.
  - d_req and not d_we: latch block base = d_addr with low log2(2*BLOCK_WORDS) bits zeroed, owner=D, go to READ.
  - else i_req: latch block base of i_addr, owner=I, go to READ.
  - No memory activity is driven in IDLE.
- READ:
  - Issue phase: mem_enable=1 on each of the first BLOCK_WORDS READ cycles; mem_addr = base + 2*issue_cnt; issue_cnt increments 0..BLOCK_WORDS-1, then mem_enable=0.
  - Return phase: each mem_data_valid cycle, the owner's *_fill_valid=1, fill_data=mem_rdata, fill_word=recv_cnt; recv_cnt then increments.
  - Returns may overlap issue.
  - Completion: on the valid with recv_cnt = BLOCK_WORDS-1, pulse the owner's done in the same cycle and go to RELEASE.
- WRITE: one cycle with mem_enable=1, mem_wr=1, mem_addr=latched address, mem_wdata=latched data; d_done=1 in that cycle; go to RELEASE.
- RELEASE: one idle cycle with no arbitration, so a requester that drops req on the edge after done is never re-granted. Go to IDLE.
- Minimum total latency:
  - Block read: 1 (IDLE grant) + memory latency + BLOCK_WORDS cycles to last word, then RELEASE.
  - Write: grant + 1 cycle.
- Starvation: the instruction side can wait on a data-side stream. This is acceptable because the pipeline stalls on data misses.
- Ignored inputs:
  - mem_data_valid outside READ is ignored; no fill_valid is asserted.
  - Request deassertion or address change after grant does not affect the transaction.
  - The non-owner's req is held pending, not dropped.
- Never both i_fill_valid and d_fill_valid; never both done pulses in one cycle.
- Counters wrap only via reset to 0 at transaction start. fill_word never exceeds BLOCK_WORDS-1.

Test Plan:
- I-miss alone:
  - Stimulus: reset, then i_req=1, i_addr=0x1236; memory latency 4.
  - Response: mem_addr 0x1230,0x1232,…,0x123E on 8 consecutive cycles; i_fill_valid ×8 with fill_word 0..7; i_done on the 8th valid; no d_* activity.
- Simultaneous requests:
  - Stimulus: i_req and d_req (read, d_addr=0x0040) raised in the same cycle.
  - Response: data block 0x0040–0x004E serviced first with d_done; then RELEASE, IDLE, and the I block starts exactly 2 cycles after d_done.
- Store:
  - Stimulus: d_req=1, d_we=1, d_addr=0x00A4, d_wdata=0xBEEF.
  - Response: one cycle with mem_enable=1, mem_wr=1, mem_addr=0x00A4, mem_wdata=0xBEEF, d_done=1; no fill_valid.
- Held request / re-grant guard:
  - Stimulus: requester drops i_req on the edge after i_done.
  - Response: no second grant. If i_req is still high in IDLE, a new read of the same block starts.
- Reset mid-read:
  - Stimulus: assert rst after 3 words returned.
  - Response: next cycle all outputs are 0, no done pulse; a new i_req restarts with fill_word 0.
- Stray valid:
  - Stimulus: pulse mem_data_valid while IDLE.
  - Response: i_fill_valid and d_fill_valid stay 0; state unchanged.

Source files
------------

// File: rtl/mem_arbiter.sv
// Shares one main-memory port between the instruction and data miss paths.
// Block reads go out as pipelined word reads; stores are single-word writes.
module mem_arbiter #(
  parameter int BLOCK_WORDS = 8,
  parameter int ADDR_W      = 16
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           i_req,
  input  logic [ADDR_W-1:0]              i_addr,
  input  logic                           d_req,
  input  logic                           d_we,
  input  logic [ADDR_W-1:0]              d_addr,
  input  logic [15:0]                    d_wdata,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic                           mem_enable,
  output logic                           mem_wr,
  output logic [15:0]                    mem_wdata,
  input  logic [15:0]                    mem_rdata,
  input  logic                           mem_data_valid,
  output logic [15:0]                    fill_data,
  output logic [$clog2(BLOCK_WORDS)-1:0] fill_word,
  output logic                           i_fill_valid,
  output logic                           d_fill_valid,
  output logic                           i_done,
  output logic                           d_done
);

  localparam int WW = $clog2(BLOCK_WORDS);
  localparam logic [ADDR_W-1:0] OFFS_MASK = ADDR_W'(2 * BLOCK_WORDS - 1);
  localparam logic [WW:0]       ISSUE_MAX = (WW + 1)'(BLOCK_WORDS);
  localparam logic [WW:0]       ISSUE_ONE = (WW + 1)'(1);
  localparam logic [WW-1:0]     RECV_LAST = WW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_READ,
    S_WRITE,
    S_RELEASE
  } state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_base;
  logic                r_owner_d;
  logic [WW:0]         r_issue_cnt;
  logic [WW-1:0]       r_recv_cnt;
  logic                r_mem_enable;
  logic                r_mem_wr;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [15:0]         r_mem_wdata;
  logic                r_wr_done;

  logic [ADDR_W-1:0]   w_i_base;
  logic [ADDR_W-1:0]   w_d_base;
  logic [ADDR_W-1:0]   w_next_addr;
  logic                w_fill;
  logic                w_last;

  assign w_i_base    = i_addr & ~OFFS_MASK;
  assign w_d_base    = d_addr & ~OFFS_MASK;
  assign w_next_addr = r_base + ADDR_W'({r_issue_cnt, 1'b0});

  // Returned words are only meaningful while a read is in flight.
  assign w_fill = (r_state == S_READ) && mem_data_valid;
  assign w_last = w_fill && (r_recv_cnt == RECV_LAST);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_base       <= '0;
      r_owner_d    <= 1'b0;
      r_issue_cnt  <= '0;
      r_recv_cnt   <= '0;
      r_mem_enable <= 1'b0;
      r_mem_wr     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_wr_done    <= 1'b0;
    end else begin
      r_wr_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Memory outputs are registered, so the first word of a read is
          // set up here and appears on the port in the first READ cycle.
          if (d_req) begin
            r_owner_d <= 1'b1;
            if (d_we) begin
              r_state      <= S_WRITE;
              r_base       <= d_addr;
              r_mem_enable <= 1'b1;
              r_mem_wr     <= 1'b1;
              r_mem_addr   <= d_addr;
              r_mem_wdata  <= d_wdata;
              r_wr_done    <= 1'b1;
            end else begin
              r_state      <= S_READ;
              r_base       <= w_d_base;
              r_mem_enable <= 1'b1;
              r_mem_addr   <= w_d_base;
              r_issue_cnt  <= ISSUE_ONE;
              r_recv_cnt   <= '0;
            end
          end else if (i_req) begin
            r_owner_d    <= 1'b0;
            r_state      <= S_READ;
            r_base       <= w_i_base;
            r_mem_enable <= 1'b1;
            r_mem_addr   <= w_i_base;
            r_issue_cnt  <= ISSUE_ONE;
            r_recv_cnt   <= '0;
          end
        end

        S_READ: begin
          if (r_issue_cnt < ISSUE_MAX) begin
            r_mem_enable <= 1'b1;
            r_mem_addr   <= w_next_addr;
            r_issue_cnt  <= r_issue_cnt + 1'b1;
          end else begin
            r_mem_enable <= 1'b0;
            r_mem_addr   <= '0;
          end
          if (mem_data_valid) begin
            r_recv_cnt <= r_recv_cnt + 1'b1;
          end
          if (w_last) begin
            r_state      <= S_RELEASE;
            r_mem_enable <= 1'b0;
            r_mem_addr   <= '0;
          end
        end

        S_WRITE: begin
          r_state      <= S_RELEASE;
          r_mem_enable <= 1'b0;
          r_mem_wr     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
        end

        S_RELEASE: begin
          // Dead cycle lets a requester drop req after done without a re-grant.
          r_state <= S_IDLE;
        end

        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign mem_enable   = r_mem_enable;
  assign mem_wr       = r_mem_wr;
  assign mem_addr     = r_mem_addr;
  assign mem_wdata    = r_mem_wdata;

  assign fill_data    = mem_rdata;
  assign fill_word    = r_recv_cnt;
  assign i_fill_valid = w_fill && !r_owner_d;
  assign d_fill_valid = w_fill && r_owner_d;
  assign i_done       = w_last && !r_owner_d;
  assign d_done       = r_wr_done || (w_last && r_owner_d);

endmodule
